// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_pkg
//  Description : Shared constants, types and the word-select decoder used by
//                the sc_computer IO-space input-port bank.
//                IO_SEL_LSB/IO_SEL_MSB : address bits that form the word select
//                IO_DEFAULT_BASE_SEL   : default select value of port 0
//                IO_STATUS_OFS/MASK_OFS: register offsets past the port block
//  Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int unsigned IO_SEL_LSB          = 2;
    localparam int unsigned IO_SEL_MSB          = 7;
    localparam logic [5:0]  IO_DEFAULT_BASE_SEL = 6'h20;
    localparam int unsigned IO_MAX_PORTS        = 8;

    // STATUS and MASK sit directly after the last port word.
    localparam int unsigned IO_STATUS_OFS = 0;
    localparam int unsigned IO_MASK_OFS   = 1;

    typedef enum logic [1:0] {
        IO_SEL_NONE   = 2'd0,
        IO_SEL_PORT   = 2'd1,
        IO_SEL_STATUS = 2'd2,
        IO_SEL_MASK   = 2'd3
    } io_sel_kind_e;

    typedef struct packed {
        io_sel_kind_e kind;
        logic [2:0]   idx;   // port index, meaningful only for IO_SEL_PORT
    } io_decode_t;

    // Offset is taken modulo 64 so selects below the base wrap to large
    // offsets and fall through to IO_SEL_NONE.
    function automatic io_decode_t io_decode(
        input logic [5:0]  sel,
        input logic [5:0]  base,
        input int unsigned nports
    );
        logic [5:0]  ofs;
        logic [31:0] ofs32;
        io_decode_t  d;
        ofs    = sel - base;
        ofs32  = {26'd0, ofs};
        d.kind = IO_SEL_NONE;
        d.idx  = ofs[2:0];
        if (ofs32 < nports) begin
            d.kind = IO_SEL_PORT;
        end else if (ofs32 == nports + IO_STATUS_OFS) begin
            d.kind = IO_SEL_STATUS;
        end else if (ofs32 == nports + IO_MASK_OFS) begin
            d.kind = IO_SEL_MASK;
        end
        return d;
    endfunction

endpackage : io_pkg
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : io_debounce
//  Description : Two-flop synchroniser followed by a word-wide debounce
//                filter. A new value is accepted once it has been seen on
//                the synchroniser output for DB_CYCLES consecutive cycles.
//  Ports       : clk      - clock, all state on posedge
//                rst_n    - asynchronous active-low reset
//                i_async  - asynchronous input word
//                o_stable - debounced, accepted value
//                o_chg    - high for the cycle in which o_stable is updated
//                           on the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module io_debounce #(
    parameter int WIDTH     = 32,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_stable,
    output logic             o_chg
);

    localparam int             CW     = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt;

    logic w_diff;
    logic w_commit;

    assign w_diff   = (r_s2 != r_stable);
    assign w_commit = w_diff && (r_cnt == C_LAST);

    // Any return of the sampled word to the accepted value restarts the
    // count, so a glitch shorter than DB_CYCLES never reaches C_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_commit) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + C_ONE;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_chg    = w_commit;

endmodule : io_debounce
`default_nettype wire

// File: rtl/io_input_bank.sv
`default_nettype none
// ============================================================================
//  Module      : io_input_bank
//  Description : Memory-mapped bank of NUM_PORTS debounced input ports with a
//                sticky change-status register, an interrupt mask and a
//                registered level interrupt.
//  Ports       : io_clk        - IO clock
//                resetn        - asynchronous active-low reset
//                addr          - CPU byte address, addr[7:2] is the word select
//                io_rd         - read strobe, qualifies STATUS clear-on-read
//                io_wr         - write strobe (MASK only)
//                io_write_data - write data
//                in_port       - asynchronous inputs, port i at [i*WIDTH +: WIDTH]
//                io_read_data  - combinational read data
//                irq           - registered |(STATUS & MASK)
//  Map         : BASE_SEL+i            port i stable value (RO)
//                BASE_SEL+NUM_PORTS    STATUS (clear-on-read)
//                BASE_SEL+NUM_PORTS+1  MASK (RW)
//  Revision    : 1.0 - initial release
// ============================================================================
module io_input_bank
    import io_pkg::*;
#(
    parameter int         NUM_PORTS = 2,
    parameter int         WIDTH     = 32,
    parameter int         DB_CYCLES = 4,
    parameter logic [5:0] BASE_SEL  = IO_DEFAULT_BASE_SEL
) (
    input  logic                       io_clk,
    input  logic                       resetn,
    input  logic [31:0]                addr,
    input  logic                       io_rd,
    input  logic                       io_wr,
    input  logic [31:0]                io_write_data,
    input  logic [NUM_PORTS*WIDTH-1:0] in_port,
    output logic [31:0]                io_read_data,
    output logic                       irq
);

    logic [WIDTH-1:0]     w_stable [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_chg;
    logic [5:0]           w_sel;
    io_decode_t           w_dec;
    logic                 w_status_clr;
    logic                 w_mask_wr;
    logic                 w_unused_bits;

    logic [NUM_PORTS-1:0] r_status;
    logic [NUM_PORTS-1:0] r_mask;
    logic                 r_irq;

    // ------------------------------------------------------------------
    // Per-port synchroniser and debounce
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        io_debounce #(
            .WIDTH     (WIDTH),
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .clk      (io_clk),
            .rst_n    (resetn),
            .i_async  (in_port[g*WIDTH +: WIDTH]),
            .o_stable (w_stable[g]),
            .o_chg    (w_chg[g])
        );
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_sel        = addr[IO_SEL_MSB:IO_SEL_LSB];
    assign w_dec        = io_decode(w_sel, BASE_SEL, NUM_PORTS);
    assign w_status_clr = io_rd && (w_dec.kind == IO_SEL_STATUS);
    assign w_mask_wr    = io_wr && (w_dec.kind == IO_SEL_MASK);

    // Address bits outside the word select and write-data bits above the
    // mask width carry no meaning for this block.
    assign w_unused_bits = ^{addr[31:IO_SEL_MSB+1], addr[IO_SEL_LSB-1:0],
                             io_write_data[31:NUM_PORTS]};

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        io_read_data = '0;
        case (w_dec.kind)
            IO_SEL_PORT: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (w_dec.idx == 3'(i)) begin
                        io_read_data[WIDTH-1:0] = w_stable[i];
                    end
                end
            end
            IO_SEL_STATUS: io_read_data[NUM_PORTS-1:0] = r_status;
            IO_SEL_MASK:   io_read_data[NUM_PORTS-1:0] = r_mask;
            default:       io_read_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // STATUS, MASK and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_status <= '0;
            r_mask   <= '0;
            r_irq    <= 1'b0;
        end else begin
            // A change landing in the same cycle as the clearing read is
            // kept, so the CPU cannot lose an event it has not yet seen.
            r_status <= (w_status_clr ? '0 : r_status) | w_chg;
            if (w_mask_wr) begin
                r_mask <= io_write_data[NUM_PORTS-1:0];
            end
            r_irq <= |(r_status & r_mask);
        end
    end

    assign irq = r_irq;

endmodule : io_input_bank
`default_nettype wire
